traffic_countdown_display: RTL

//  Downstream consumer of the traffic-light FSM. Samples its 3-bit state code (S0..S7) and derives

---
 rtl/traffic_pkg.sv | 57 +++++
 rtl/seg7_decoder.sv | 25 ++
 rtl/traffic_countdown_display.sv | 116 +++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared constants for the traffic-light countdown display: state codes,
// remaining-state tables and active-low 7-segment patterns.
package traffic_pkg;

  localparam int CNT_W  = 7;
  localparam int DIGITS = 4;

  localparam logic [2:0] S0 = 3'd0;
  localparam logic [2:0] S1 = 3'd1;
  localparam logic [2:0] S2 = 3'd2;
  localparam logic [2:0] S3 = 3'd3;
  localparam logic [2:0] S4 = 3'd4;
  localparam logic [2:0] S5 = 3'd5;
  localparam logic [2:0] S6 = 3'd6;
  localparam logic [2:0] S7 = 3'd7;

  // Segment order {g,f,e,d,c,b,a}, a lit segment is 0
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // States left in the current colour for group 1, including this one
  function automatic logic [2:0] rem1(input logic [2:0] s);
    case (s)
      S0:      rem1 = 3'd3;
      S1:      rem1 = 3'd2;
      S2:      rem1 = 3'd1;
      S3:      rem1 = 3'd1;
      S4:      rem1 = 3'd4;
      S5:      rem1 = 3'd3;
      S6:      rem1 = 3'd2;
      default: rem1 = 3'd1;
    endcase
  endfunction

  function automatic logic [2:0] rem2(input logic [2:0] s);
    case (s)
      S0:      rem2 = 3'd4;
      S1:      rem2 = 3'd3;
      S2:      rem2 = 3'd2;
      S3:      rem2 = 3'd1;
      S4:      rem2 = 3'd3;
      S5:      rem2 = 3'd2;
      S6:      rem2 = 3'd1;
      default: rem2 = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// BCD to active-low 7-segment pattern; codes above 9 produce a blank digit.
module seg7_decoder
  import traffic_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/traffic_countdown_display.sv
// Follows the traffic FSM state code, counts down seconds left per light group
// and scans the two 2-digit counts onto a 4-digit multiplexed display.
module traffic_countdown_display
  import traffic_pkg::*;
#(
  parameter int CLK_PER_SEC   = 50_000_000,
  parameter int SEC_PER_STATE = 5,
  parameter int REFRESH_DIV   = 50_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       state_in,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [3:0]       an,
  output logic [6:0]       seg
);

  localparam int SEC_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [SEC_W-1:0] SEC_MAX = SEC_W'(CLK_PER_SEC - 1);
  localparam logic [REF_W-1:0] REF_MAX = REF_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] SPS     = CNT_W'(SEC_PER_STATE);
  localparam logic [CNT_W-1:0] TEN     = CNT_W'(10);

  logic             loaded_q, loaded_d;
  logic [2:0]       prev_state_q, prev_state_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic [REF_W-1:0] ref_q, ref_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  logic       reload, sec_wrap;
  logic [3:0] ones1, tens1, ones2, tens2, bcd_sel;
  logic [6:0] seg_dec;

  // Countdown: a state change (or the first cycle out of reset) reloads and
  // takes priority over a coincident one-second tick.
  always_comb begin
    reload       = !loaded_q || (state_in != prev_state_q);
    sec_wrap     = (sec_q == SEC_MAX);
    loaded_d     = loaded_q;
    prev_state_d = prev_state_q;
    sec_d        = sec_q;
    cnt1_d       = cnt1_q;
    cnt2_d       = cnt2_q;
    if (reload) begin
      loaded_d     = 1'b1;
      prev_state_d = state_in;
      sec_d        = '0;
      cnt1_d       = CNT_W'(rem1(state_in)) * SPS;
      cnt2_d       = CNT_W'(rem2(state_in)) * SPS;
    end else begin
      sec_d = sec_wrap ? '0 : sec_q + SEC_W'(1);
      if (sec_wrap) begin
        if (cnt1_q != '0) cnt1_d = cnt1_q - CNT_W'(1);
        if (cnt2_q != '0) cnt2_d = cnt2_q - CNT_W'(1);
      end
    end
  end

  // Display scan: a zero tens digit is fed as an out-of-range code to blank it
  always_comb begin
    ref_d = (ref_q == REF_MAX) ? '0 : ref_q + REF_W'(1);
    idx_d = (ref_q == REF_MAX) ? idx_q + 2'd1 : idx_q;
    ones1 = 4'(cnt1_q % TEN);
    tens1 = 4'(cnt1_q / TEN);
    ones2 = 4'(cnt2_q % TEN);
    tens2 = 4'(cnt2_q / TEN);
    case (idx_q)
      2'd0:    bcd_sel = ones1;
      2'd1:    bcd_sel = (tens1 == 4'd0) ? 4'hF : tens1;
      2'd2:    bcd_sel = ones2;
      default: bcd_sel = (tens2 == 4'd0) ? 4'hF : tens2;
    endcase
    an_d  = loaded_q ? ~(4'b0001 << idx_q) : 4'b1111;
    seg_d = loaded_q ? seg_dec : SEG_BLANK;
  end

  seg7_decoder u_dec (
    .bcd (bcd_sel),
    .seg (seg_dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      loaded_q     <= 1'b0;
      prev_state_q <= S0;
      sec_q        <= '0;
      ref_q        <= '0;
      idx_q        <= '0;
      cnt1_q       <= '0;
      cnt2_q       <= '0;
      an_q         <= 4'b1111;
      seg_q        <= SEG_BLANK;
    end else begin
      loaded_q     <= loaded_d;
      prev_state_q <= prev_state_d;
      sec_q        <= sec_d;
      ref_q        <= ref_d;
      idx_q        <= idx_d;
      cnt1_q       <= cnt1_d;
      cnt2_q       <= cnt2_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign cnt1 = cnt1_q;
  assign cnt2 = cnt2_q;
  assign an   = an_q;
  assign seg  = seg_q;

endmodule
